// File: rtl/tpu_pkg.sv
// Shared types for the TPU input feeder.
// Provides the default array geometry, the buffered row payload and the
// feeder FSM state encoding.
package tpu_pkg;

    localparam int unsigned N_DEF      = 8;
    localparam int unsigned DATA_W_DEF = 8;

    // One host beat: an activation row, a weight row and the tile-end marker.
    typedef struct packed {
        logic [N_DEF-1:0][DATA_W_DEF-1:0] data;
        logic [N_DEF-1:0][DATA_W_DEF-1:0] weight;
        logic                             last;
    } row_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } feeder_state_e;

endpackage

// File: rtl/tpu_row_fifo.sv
// Synchronous show-ahead FIFO for feeder rows.
// Ports:
//   clk, rst      clock, synchronous active-high reset (empties the FIFO)
//   push_i        write push_data_i when not full
//   push_data_i   entry to store
//   pop_i         drop the head entry when not empty
//   head_o        current head entry (valid while empty_o is low)
//   count_o       registered occupancy
//   full_o        registered, occupancy == DEPTH
//   empty_o       registered, occupancy == 0
module tpu_row_fifo
    import tpu_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter type         entry_t = row_t
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  entry_t                     push_data_i,
    input  logic                       pop_i,
    output entry_t                     head_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    entry_t          mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q,  count_d;
    logic            full_q,   full_d;
    logic            empty_q,  empty_d;
    logic            push_ok;
    logic            pop_ok;

    // Push is refused when full even if a pop happens in the same cycle.
    always_comb begin
        push_ok  = push_i && !full_q;
        pop_ok   = pop_i && !empty_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + CW'(1);
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - CW'(1);
        end
        full_d  = (count_d == CW'(DEPTH));
        empty_d = (count_d == '0);
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign full_o  = full_q;
    assign empty_o = empty_q;

endmodule

// File: rtl/tpu_feeder.sv
// Host-side transmitter for the systolic array input interface.
// Buffers host rows, skews them so lane k lags lane 0 by k cycles, and
// forces a drain gap after each tile's last row.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   in_valid_i/in_ready_o        host row handshake
//   in_data_i, in_weight_i       row payload, element k goes to lane k
//   in_last_i                    row closes the current tile
//   sysdata_o, sysweight_o       skewed lanes to the array
//   valid_input_o/valid_weight_o per-lane valids
//   busy_o                       tile in progress
//   tile_done_o                  one-cycle pulse at the end of drain
//   tile_rows_o                  rows in the last completed tile (saturating)
//   overrun_o                    pulses with tile_done_o if the tile overflowed
module tpu_feeder
    import tpu_pkg::*;
#(
    parameter int unsigned N          = N_DEF,
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned DRAIN_CYC  = 16,
    parameter int unsigned MAX_ROWS   = 256
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid_i,
    output logic                            in_ready_o,
    input  logic [N-1:0][DATA_W-1:0]        in_data_i,
    input  logic [N-1:0][DATA_W-1:0]        in_weight_i,
    input  logic                            in_last_i,
    output logic [N-1:0][DATA_W-1:0]        sysdata_o,
    output logic [N-1:0][DATA_W-1:0]        sysweight_o,
    output logic [N-1:0]                    valid_input_o,
    output logic [N-1:0]                    valid_weight_o,
    output logic                            busy_o,
    output logic                            tile_done_o,
    output logic [$clog2(MAX_ROWS+1)-1:0]   tile_rows_o,
    output logic                            overrun_o
);

    localparam int unsigned RW  = $clog2(MAX_ROWS + 1);
    localparam int unsigned DCW = $clog2(DRAIN_CYC + 1);
    localparam int unsigned FCW = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic [N-1:0][DATA_W-1:0] data;
        logic [N-1:0][DATA_W-1:0] weight;
        logic                     last;
    } feed_row_t;

    feed_row_t                push_row;
    feed_row_t                head_row;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic [FCW-1:0]           fifo_level_unused;

    feeder_state_e            state_q;
    logic [DCW-1:0]           drain_cnt_q;
    logic                     busy_q;
    logic [RW-1:0]            row_cnt_q;
    logic                     ovf_q;
    logic                     tile_done_q;
    logic [RW-1:0]            tile_rows_q;
    logic                     overrun_q;

    logic [N-1:0][DATA_W-1:0] cap_data_q;
    logic [N-1:0][DATA_W-1:0] cap_wgt_q;
    logic [N-1:0]             cap_vld_q;

    logic                     pop_c;
    logic                     row_sat_c;
    logic [RW-1:0]            row_cnt_nx_c;
    logic                     ovf_nx_c;
    logic                     finish_c;

    assign push_row.data   = in_data_i;
    assign push_row.weight = in_weight_i;
    assign push_row.last   = in_last_i;

    tpu_row_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .entry_t (feed_row_t)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (in_valid_i),
        .push_data_i (push_row),
        .pop_i       (pop_c),
        .head_o      (head_row),
        .count_o     (fifo_level_unused),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    assign in_ready_o = !fifo_full;

    // Rows leave the buffer in IDLE and STREAM only; DRAIN holds them back.
    assign pop_c = !fifo_empty && ((state_q == IDLE) || (state_q == STREAM));

    // Saturating per-tile row count; bubbles never reach it.
    assign row_sat_c    = (row_cnt_q == RW'(MAX_ROWS));
    assign row_cnt_nx_c = (pop_c && !row_sat_c) ? row_cnt_q + RW'(1) : row_cnt_q;
    assign ovf_nx_c     = ovf_q | (pop_c & row_sat_c);

    // Close the tile on the edge that brings the drain counter to zero.
    assign finish_c = ((state_q == DRAIN) && (drain_cnt_q == DCW'(1)))
                   || ((DRAIN_CYC == 1) && pop_c && head_row.last);

    // Feeder FSM with tile bookkeeping and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            drain_cnt_q <= '0;
            busy_q      <= 1'b0;
            row_cnt_q   <= '0;
            ovf_q       <= 1'b0;
            tile_done_q <= 1'b0;
            tile_rows_q <= '0;
            overrun_q   <= 1'b0;
        end else begin
            tile_done_q <= 1'b0;
            overrun_q   <= 1'b0;
            if (finish_c) begin
                tile_done_q <= 1'b1;
                tile_rows_q <= row_cnt_nx_c;
                overrun_q   <= ovf_nx_c;
                row_cnt_q   <= '0;
                ovf_q       <= 1'b0;
            end else begin
                row_cnt_q   <= row_cnt_nx_c;
                ovf_q       <= ovf_nx_c;
            end
            unique case (state_q)
                IDLE, STREAM: begin
                    // An empty FIFO in STREAM simply leaves a bubble row.
                    if (pop_c && head_row.last) begin
                        state_q     <= DRAIN;
                        drain_cnt_q <= DCW'(DRAIN_CYC - 1);
                        busy_q      <= 1'b1;
                    end else if (pop_c) begin
                        state_q     <= STREAM;
                        busy_q      <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (drain_cnt_q == '0) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        drain_cnt_q <= drain_cnt_q - DCW'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Common capture stage; anything not popped becomes an all-zero bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            cap_data_q <= '0;
            cap_wgt_q  <= '0;
            cap_vld_q  <= '0;
        end else if (pop_c) begin
            cap_data_q <= head_row.data;
            cap_wgt_q  <= head_row.weight;
            cap_vld_q  <= '1;
        end else begin
            cap_data_q <= '0;
            cap_wgt_q  <= '0;
            cap_vld_q  <= '0;
        end
    end

    // Diagonal skew: lane k adds k free-running stages after the capture stage.
    for (genvar k = 0; k < N; k++) begin : g_lane
        if (k == 0) begin : g_direct
            assign sysdata_o[k]      = cap_data_q[k];
            assign sysweight_o[k]    = cap_wgt_q[k];
            assign valid_input_o[k]  = cap_vld_q[k];
            assign valid_weight_o[k] = cap_vld_q[k];
        end else begin : g_chain
            logic [DATA_W-1:0] dat_q [k];
            logic [DATA_W-1:0] wgt_q [k];
            logic              vld_q [k];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int s = 0; s < k; s++) begin
                        dat_q[s] <= '0;
                        wgt_q[s] <= '0;
                        vld_q[s] <= 1'b0;
                    end
                end else begin
                    dat_q[0] <= cap_data_q[k];
                    wgt_q[0] <= cap_wgt_q[k];
                    vld_q[0] <= cap_vld_q[k];
                    for (int s = 1; s < k; s++) begin
                        dat_q[s] <= dat_q[s-1];
                        wgt_q[s] <= wgt_q[s-1];
                        vld_q[s] <= vld_q[s-1];
                    end
                end
            end

            assign sysdata_o[k]      = dat_q[k-1];
            assign sysweight_o[k]    = wgt_q[k-1];
            assign valid_input_o[k]  = vld_q[k-1];
            assign valid_weight_o[k] = vld_q[k-1];
        end
    end

    assign busy_o      = busy_q;
    assign tile_done_o = tile_done_q;
    assign tile_rows_o = tile_rows_q;
    assign overrun_o   = overrun_q;

endmodule

// File: doc/tpu_feeder.md
Name: tpu_feeder

Overview:
Host-side transmitter for the TPU systolic array's input interface. Accepts one row of N activation bytes plus N weight bytes per ready/valid beat and buffers rows in a small FIFO. Applies the diagonal skew the array needs, so lane k lags lane 0 by k cycles, and drives the per-lane data/weight valid bits. After the last row of each tile it inserts a fixed drain gap so the array can flush its partial sums.

Parameters:
N, 8, array dimension / lanes per row
DATA_W, 8, activation and weight element width
FIFO_DEPTH, 4, input row buffer depth (power of 2, >=2)
DRAIN_CYC, 16, cycles of forced idle after a tile's last row; must be >= N
MAX_ROWS, 256, row-count saturation limit per tile

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
in_valid_i  in  1  host row valid
in_ready_o  out  1  feeder can accept a row
in_data_i  in  N x DATA_W  activation row, element k goes to lane k
in_weight_i  in  N x DATA_W  weight row, element k goes to lane k
in_last_i  in  1  row is the last of the current tile
sysdata_o  out  N x DATA_W  skewed activations to array
sysweight_o  out  N x DATA_W  skewed weights to array
valid_input_o  out  N  per-lane activation valid
valid_weight_o  out  N  per-lane weight valid
busy_o  out  1  tile in progress (state != IDLE)
tile_done_o  out  1  one-cycle pulse at end of drain
tile_rows_o  out  $clog2(MAX_ROWS+1)  rows in last completed tile
overrun_o  out  1  pulses with tile_done_o if tile exceeded MAX_ROWS

Behaviour:
- Interface: clock clk; reset rst, synchronous, active-high.
- Reset:
  - FIFO emptied, state IDLE, skew registers cleared.
  - All data/valid outputs 0; busy_o, tile_done_o and overrun_o 0; tile_rows_o 0.
  - in_ready_o is 1 in the first cycle after reset.
- Reset mid-tile: in-flight rows and FIFO contents are discarded. No tile_done_o pulse.
- Input handshake:
  - Push when in_valid_i && in_ready_o.
  - in_ready_o = !full, based on the registered count. No push to a full FIFO, even if a pop happens in the same cycle.
  - Push and pop in the same cycle are legal when the FIFO is not full; the count is unchanged.
- FSM:
  - IDLE: pop the head if FIFO is non-empty. If the popped entry has last=1, go to DRAIN; otherwise go to STREAM.
  - STREAM: pop one row per cycle while FIFO is non-empty. If FIFO is empty, inject a bubble row (all lane valids 0, data 0) and stay in STREAM. Popping an entry with last=1 goes to DRAIN.
  - DRAIN: no pops. A down-counter is loaded with DRAIN_CYC-1 on entry. When the counter reaches 0, assert tile_done_o and go to IDLE. A pop is allowed in the next cycle.
- Drain timing: last row popped at cycle t → DRAIN occupies t+1..t+DRAIN_CYC → tile_done_o at t+DRAIN_CYC.
- Skew and latency:
  - A row popped at cycle t appears on lane k (data, weight, both valids) at cycle t+1+k.
  - Lane k uses a k-stage register chain after the common capture register.
  - Valid bits travel with their data. An invalid lane drives data 0.
  - The skew pipeline never stalls; the array has no backpressure.
- Row counting:
  - The counter increments on each popped row (bubbles excluded) and saturates at MAX_ROWS.
  - If a pop is attempted at saturation, an overrun flag is set.
  - At tile_done_o: tile_rows_o takes the counter value, overrun_o pulses if the flag is set, then the counter and flag clear.
- Widths: no arithmetic on data; the count is unsigned.

Decomposition:
- Shared package tpu_pkg: N_DEF, DATA_W_DEF, a row_t typedef (packed data[N], weight[N], last), and the feeder_state_e enum {IDLE, STREAM, DRAIN}.
- One sub-module, tpu_row_fifo: parameterised synchronous FIFO of row_t with count, full and empty outputs. The skew chain and FSM stay in tpu_feeder.

Test Plan:
All scenarios use N=8, DRAIN_CYC=16.
- Single-row tile: push data=0x01..0x08, last=1 at cycle 0 → lane k valid with data k+1 at cycle 2+k; tile_done_o at cycle 17; tile_rows_o=1.
- Back-to-back 4-row tile, rows r0..r3 each filled with value r: lane 7 shows 0,1,2,3 on consecutive cycles. Two adjacent lanes are offset by exactly one cycle. tile_rows_o=4.
- Host gap: push r0, idle 2 cycles, push r1 (last) → two bubble rows: valid_input_o all 0 for lane k on the two cycles between r0 and r1. Bubbles are not counted; tile_rows_o=2.
- Backpressure: hold in_valid_i high through DRAIN with 6 queued rows → in_ready_o drops after 4 entries. No pops during DRAIN. Next tile's first row appears on lane 0 one cycle after IDLE is re-entered.
- Reset mid-tile: assert rst for 1 cycle while 3 rows are in the skew chain → all valids 0 the next cycle, FIFO empty, no tile_done_o, in_ready_o=1.
- Overrun with MAX_ROWS=4: push a 6-row tile → tile_rows_o=4 and overrun_o pulses with tile_done_o.
